apb_master_bridge: RTL

//  Single-outstanding APB master sitting directly upstream of the APB slave array.

---
 rtl/apb_master_bridge_pkg.sv | 15 +
 rtl/apb_master_bridge_wait_timer.sv | 30 +++
 rtl/apb_master_bridge.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the APB master bridge: FSM encodings and default widths.
// Optional ACCESS-phase timeout is enabled with the APB_TIMEOUT_EN macro.
package apb_master_bridge_pkg;

  localparam int APB_ADDR_W      = 8;
  localparam int APB_DATA_W      = 8;
  localparam int APB_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_wait_timer.sv
// ACCESS-phase wait counter with terminal-count flag for the APB master bridge.
// Only exists when APB_TIMEOUT_EN is defined; the default build has no timer.
`ifdef APB_TIMEOUT_EN
module apb_master_bridge_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_count;

  // Expiry fires on the edge that would make the TIMEOUT_CYC-th wait cycle.
  assign o_expire = i_inc && (r_count == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_expire) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: valid/ready command in, IDLE/SETUP/ACCESS phases out,
// one-cycle response pulse back. Define APB_TIMEOUT_EN to abort stalled ACCESS phases.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic              i_pclk,
  input  logic              i_preset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYC must be at least 1");
  end

  apb_state_e        r_state, w_state;
  logic              r_psel, w_psel;
  logic              r_penable, w_penable;
  logic              r_pwrite, w_pwrite;
  logic [ADDR_W-1:0] r_paddr, w_paddr;
  logic [DATA_W-1:0] r_pwdata, w_pwdata;
  logic              r_rsp_valid, w_rsp_valid;
  logic              r_rsp_err, w_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
  logic              w_cmd_ready;
  logic              w_timeout;

  assign w_cmd_ready = (r_state == ST_IDLE) && !i_preset;

`ifdef APB_TIMEOUT_EN
  apb_master_bridge_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .i_clk    (i_pclk),
    .i_reset  (i_preset),
    .i_clr    (r_state == ST_SETUP),
    .i_inc    ((r_state == ST_ACCESS) && !i_pready),
    .o_expire (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and next-output logic; response fields hold until the next completion.
  always_comb begin
    w_state     = r_state;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_pwrite    = r_pwrite;
    w_paddr     = r_paddr;
    w_pwdata    = r_pwdata;
    w_rsp_valid = 1'b0;
    w_rsp_err   = r_rsp_err;
    w_rsp_rdata = r_rsp_rdata;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid && w_cmd_ready) begin
          w_state   = ST_SETUP;
          w_psel    = 1'b1;
          w_penable = 1'b0;
          w_pwrite  = i_cmd_write;
          w_paddr   = i_cmd_addr;
          w_pwdata  = i_cmd_wdata;
        end
      end
      ST_SETUP: begin
        w_state   = ST_ACCESS;
        w_penable = 1'b1;
      end
      ST_ACCESS: begin
        // A slave completing on the expiry edge takes priority over the abort.
        if (i_pready) begin
          w_state     = ST_IDLE;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = i_pslverr;
          w_rsp_rdata = r_pwrite ? '0 : i_prdata;
        end else if (w_timeout) begin
          w_state     = ST_IDLE;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_rsp_rdata = '0;
        end
      end
      default: begin
        w_state   = ST_IDLE;
        w_psel    = 1'b0;
        w_penable = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
    end
  end

  assign o_cmd_ready = w_cmd_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_pwrite    = r_pwrite;
  assign o_paddr     = r_paddr;
  assign o_pwdata    = r_pwdata;

endmodule
